logicnet_input_quantizer: RTL and testbench

Upstream front-end of the sparse LogicNet classifier. It takes raw signed fixed-point feature samples as a valid/ready stream, one feature per beat. Each feature is quantized to an IN_BITS code against programmable per-feature thresholds. The codes are packed into one wide vector that feeds the first LUT layer's input bus, with a registered valid/ready output.

---
 rtl/logicnet_input_quantizer_pkg.sv | 29 ++
 rtl/logicnet_input_quantizer_if.sv | 34 +++
 rtl/logicnet_feature_quantizer.sv | 23 ++
 rtl/logicnet_input_quantizer.sv | 159 +++++++++++++++
 tb/tb_logicnet_input_quantizer.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/logicnet_input_quantizer_pkg.sv
// Shared types and helpers for the LogicNet input quantizer.
package logicnet_quant_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EMIT    = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  // Number of thresholds needed to produce an in_bits-wide code.
  function automatic int unsigned nt_of(input int unsigned in_bits);
    return (32'd1 << in_bits) - 32'd1;
  endfunction

  // Evenly spaced ascending thresholds spanning -2^(W-2) .. +2^(W-2).
  function automatic longint default_thr(input int unsigned feat_w,
                                         input int unsigned in_bits,
                                         input int unsigned k);
    longint lo;
    longint span;
    longint nt;
    lo   = -(longint'(1) <<< (feat_w - 2));
    span = longint'(1) <<< (feat_w - 1);
    nt   = longint'(nt_of(in_bits));
    if (nt <= 1) return 64'sd0;
    return lo + (span * longint'(k)) / (nt - 1);
  endfunction

endpackage

// File: rtl/logicnet_input_quantizer_if.sv
// Sample stream, threshold config port and packed code stream.
interface logicnet_input_quantizer_if
  import logicnet_quant_pkg::*;
#(
  parameter int unsigned NUM_FEATURES = 16,
  parameter int unsigned FEAT_W       = 16,
  parameter int unsigned IN_BITS      = 2
);
  localparam int unsigned NT     = nt_of(IN_BITS);
  localparam int unsigned CFG_AW = $clog2(NUM_FEATURES * NT);
  localparam int unsigned VEC_W  = NUM_FEATURES * IN_BITS;

  logic              s_valid;
  logic              s_ready;
  logic [FEAT_W-1:0] s_data;
  logic              s_last;
  logic              cfg_we;
  logic [CFG_AW-1:0] cfg_addr;
  logic [FEAT_W-1:0] cfg_data;
  logic              m_valid;
  logic              m_ready;
  logic [VEC_W-1:0]  m_data;
  logic              err_framing;

  modport master (
    output s_valid, s_data, s_last, cfg_we, cfg_addr, cfg_data, m_ready,
    input  s_ready, m_valid, m_data, err_framing
  );

  modport slave (
    input  s_valid, s_data, s_last, cfg_we, cfg_addr, cfg_data, m_ready,
    output s_ready, m_valid, m_data, err_framing
  );
endinterface

// File: rtl/logicnet_feature_quantizer.sv
// Comparator bank: code = number of thresholds the sample meets or exceeds.
module logicnet_feature_quantizer
  import logicnet_quant_pkg::*;
#(
  parameter int unsigned FEAT_W  = 16,
  parameter int unsigned IN_BITS = 2
) (
  input  logic [FEAT_W-1:0]                  sample,
  input  logic [nt_of(IN_BITS)*FEAT_W-1:0]   thr,
  output logic [IN_BITS-1:0]                 code_c
);
  localparam int unsigned NT = nt_of(IN_BITS);

  // Signed count; thresholds need not be monotonic.
  always_comb begin
    code_c = '0;
    for (int k = 0; k < int'(NT); k++) begin
      if ($signed(sample) >= $signed(thr[k*FEAT_W +: FEAT_W])) begin
        code_c = code_c + IN_BITS'(1);
      end
    end
  end
endmodule

// File: rtl/logicnet_input_quantizer.sv
// Frames a feature stream into one packed vector of quantized codes.
module logicnet_input_quantizer
  import logicnet_quant_pkg::*;
#(
  parameter int unsigned NUM_FEATURES = 16,
  parameter int unsigned FEAT_W       = 16,
  parameter int unsigned IN_BITS      = 2
) (
  input logic                       clk,
  input logic                       rst,
  logicnet_input_quantizer_if.slave bus
);
  localparam int unsigned NT       = nt_of(IN_BITS);
  localparam int unsigned NTHR     = NUM_FEATURES * NT;
  localparam int unsigned CFG_AW   = $clog2(NTHR);
  localparam int unsigned IDX_W    = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int unsigned VEC_W    = NUM_FEATURES * IN_BITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_nxt;
  logic               drain;
  logic               drain_nxt;
  logic               s_ready;
  logic               s_ready_nxt;
  logic               m_valid;
  logic               m_valid_nxt;
  logic               err;
  logic               err_nxt;
  logic               store;
  logic               load;
  logic               accept;
  logic [VEC_W-1:0]   m_data;
  logic [VEC_W-1:0]   vec_c;
  logic [FEAT_W-1:0]  thr [NTHR];
  logic [IN_BITS-1:0] slot [NUM_FEATURES];
  logic [NT*FEAT_W-1:0] thr_sel;
  logic [IN_BITS-1:0] code_c;

  assign accept          = bus.s_valid & s_ready;
  assign bus.s_ready     = s_ready;
  assign bus.m_valid     = m_valid;
  assign bus.m_data      = m_data;
  assign bus.err_framing = err;

  // Threshold set of the feature currently being collected.
  always_comb begin
    thr_sel = '0;
    for (int k = 0; k < int'(NT); k++) begin
      thr_sel[k*FEAT_W +: FEAT_W] = thr[CFG_AW'(32'(idx) * NT + 32'(k))];
    end
  end

  logicnet_feature_quantizer #(
    .FEAT_W  (FEAT_W),
    .IN_BITS (IN_BITS)
  ) u_quant (
    .sample (bus.s_data),
    .thr    (thr_sel),
    .code_c (code_c)
  );

  // Full vector with the final feature's code taken straight from the comparator.
  always_comb begin
    vec_c = '0;
    for (int i = 0; i < int'(NUM_FEATURES); i++) begin
      vec_c[i*IN_BITS +: IN_BITS] = (i == int'(NUM_FEATURES) - 1) ? code_c : slot[IDX_W'(i)];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  // Next-state decision.
  always_comb begin
    state_nxt = state;
    unique case (state)
      COLLECT: if (accept && idx == LAST_IDX) state_nxt = EMIT;
      EMIT:    if (m_valid && bus.m_ready) state_nxt = drain ? DRAIN : COLLECT;
      DRAIN:   if (accept && bus.s_last) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // Next values of the registered outputs and datapath controls.
  always_comb begin
    idx_nxt     = idx;
    drain_nxt   = drain;
    m_valid_nxt = m_valid;
    err_nxt     = 1'b0;
    store       = 1'b0;
    load        = 1'b0;
    s_ready_nxt = (state_nxt != EMIT);
    unique case (state)
      COLLECT: begin
        if (accept) begin
          if (idx == LAST_IDX) begin
            store       = 1'b1;
            load        = 1'b1;
            m_valid_nxt = 1'b1;
            idx_nxt     = '0;
            if (!bus.s_last) begin
              err_nxt   = 1'b1;
              drain_nxt = 1'b1;
            end
          end else if (bus.s_last) begin
            err_nxt = 1'b1;
            idx_nxt = '0;
          end else begin
            store   = 1'b1;
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      EMIT:    if (m_valid && bus.m_ready) m_valid_nxt = 1'b0;
      DRAIN:   if (accept && bus.s_last) drain_nxt = 1'b0;
      default: ;
    endcase
  end

  // Control and handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      drain   <= 1'b0;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      err     <= 1'b0;
    end else begin
      idx     <= idx_nxt;
      drain   <= drain_nxt;
      s_ready <= s_ready_nxt;
      m_valid <= m_valid_nxt;
      err     <= err_nxt;
    end
  end

  // Threshold table, code slots and output vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < int'(NTHR); j++) begin
        thr[CFG_AW'(j)] <= FEAT_W'(default_thr(FEAT_W, IN_BITS, 32'(j) % NT));
      end
      for (int i = 0; i < int'(NUM_FEATURES); i++) begin
        slot[IDX_W'(i)] <= '0;
      end
      m_data <= '0;
    end else begin
      if (bus.cfg_we && 32'(bus.cfg_addr) < NTHR) thr[bus.cfg_addr] <= bus.cfg_data;
      if (store) slot[idx] <= code_c;
      if (load)  m_data <= vec_c;
    end
  end
endmodule

// File: tb/tb_logicnet_input_quantizer.sv
// Randomized self-checking bench with a frame-level reference model.
`timescale 1ns/1ps
module tb_logicnet_input_quantizer;
  localparam int unsigned N  = 16;
  localparam int unsigned FW = 16;
  localparam int unsigned IB = 2;
  localparam int unsigned NT = 3;
  localparam int unsigned VW = N * IB;
  localparam int unsigned AW = $clog2(N * NT);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logicnet_input_quantizer_if #(.NUM_FEATURES(N), .FEAT_W(FW), .IN_BITS(IB)) bus();

  logicnet_input_quantizer #(.NUM_FEATURES(N), .FEAT_W(FW), .IN_BITS(IB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int asserts = 0;
  int fails   = 0;
  int cyc     = 0;
  int err_seen = 0;
  logic [VW-1:0] got_q[$];

  // Reference model state.
  int thr_m [N][NT];
  logic [VW-1:0] exp_q[$];
  int exp_err = 0;
  int part = 0;
  logic [VW-1:0] part_vec = '0;
  bit draining = 1'b0;
  int chk = 0;

  // Observe handshakes and error pulses with pre-edge values.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (bus.m_valid && bus.m_ready) got_q.push_back(bus.m_data);
      if (bus.err_framing) err_seen++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ref_code(input int f, input logic [FW-1:0] d);
    int c = 0;
    for (int k = 0; k < int'(NT); k++) if ($signed(d) >= thr_m[f][k]) c++;
    return c;
  endfunction

  function automatic void model_reset();
    for (int f = 0; f < int'(N); f++) begin
      thr_m[f][0] = -(1 << (FW - 2));
      thr_m[f][1] = 0;
      thr_m[f][2] = (1 << (FW - 2));
    end
    part = 0;
    draining = 1'b0;
  endfunction

  function automatic void model_beat(input logic [FW-1:0] d, input bit last);
    if (draining) begin
      if (last) draining = 1'b0;
    end else begin
      part_vec[part*IB +: IB] = IB'(ref_code(part, d));
      part++;
      if (part == int'(N)) begin
        exp_q.push_back(part_vec);
        if (!last) begin exp_err++; draining = 1'b1; end
        part = 0;
      end else if (last) begin
        exp_err++;
        part = 0;
      end
    end
  endfunction

  // Starts and ends on a falling edge; beat is accepted at the rising edge in between.
  task automatic beat(input logic [FW-1:0] d, input bit last);
    int n = 0;
    model_beat(d, last);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    while (!bus.s_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      asserts++; fails++;
      $display("FAIL beat_timeout: s_ready stayed %b for %0d cycles, required 1", bus.s_ready, n);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic cfg_write(input int f, input int k, input logic [FW-1:0] v);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = AW'(f * int'(NT) + k);
    bus.cfg_data = v;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    thr_m[f][k] = int'($signed(v));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.s_valid = 0; bus.s_data = '0; bus.s_last = 0;
    bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.m_ready = 1'b1;
    repeat (2) @(negedge clk);
    asserts++; if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL rst_s_ready got %b exp 0", bus.s_ready); end
    asserts++; if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL rst_m_valid got %b exp 0", bus.m_valid); end
    asserts++; if (bus.m_data !== '0) begin fails++; $display("FAIL rst_m_data got %h exp 0", bus.m_data); end
    asserts++; if (bus.err_framing !== 1'b0) begin fails++; $display("FAIL rst_err got %b exp 0", bus.err_framing); end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    asserts++; if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL rst_release_s_ready got %b exp 1", bus.s_ready); end
  endtask

  task automatic test_default_quant();
    logic [FW-1:0] pat [4];
    pat[0] = 16'(-20000); pat[1] = 16'(-1); pat[2] = 16'(0); pat[3] = 16'(20000);
    for (int b = 0; b < int'(N); b++) beat(pat[b % 4], b == int'(N) - 1);
    asserts++; if (bus.m_valid !== 1'b1) begin fails++; $display("FAIL dflt_latency m_valid got %b exp 1", bus.m_valid); end
    asserts++; if (bus.m_data !== 32'hE4E4E4E4) begin fails++; $display("FAIL dflt_codes got %h exp e4e4e4e4", bus.m_data); end
    @(negedge clk);
    asserts++; if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL dflt_pulse m_valid got %b exp 0", bus.m_valid); end
    repeat (3) @(negedge clk);
    asserts++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL dflt_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (chk < exp_q.size() && chk < got_q.size()) begin
      asserts++; if (got_q[chk] !== exp_q[chk]) begin fails++; $display("FAIL dflt_vec[%0d] got %h exp %h", chk, got_q[chk], exp_q[chk]); end
      chk++;
    end
    asserts++; if (err_seen !== exp_err) begin fails++; $display("FAIL dflt_err got %0d exp %0d", err_seen, exp_err); end
  endtask

  task automatic test_program_thr();
    cfg_write(0, 0, 16'd100);
    cfg_write(0, 1, 16'd200);
    cfg_write(0, 2, 16'd300);
    for (int b = 0; b < int'(N); b++) beat((b == 0) ? 16'd250 : 16'd0, b == int'(N) - 1);
    asserts++; if (bus.m_data !== 32'hAAAAAAAA) begin fails++; $display("FAIL prog_codes got %h exp aaaaaaaa", bus.m_data); end
    repeat (3) @(negedge clk);
    asserts++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL prog_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (chk < exp_q.size() && chk < got_q.size()) begin
      asserts++; if (got_q[chk] !== exp_q[chk]) begin fails++; $display("FAIL prog_vec[%0d] got %h exp %h", chk, got_q[chk], exp_q[chk]); end
      chk++;
    end
    asserts++; if (err_seen !== exp_err) begin fails++; $display("FAIL prog_err got %0d exp %0d", err_seen, exp_err); end
  endtask

  task automatic test_short_frame();
    int e0 = err_seen;
    for (int b = 0; b < 5; b++) beat(16'($urandom), b == 4);
    asserts++; if (bus.err_framing !== 1'b1) begin fails++; $display("FAIL short_err_pulse got %b exp 1", bus.err_framing); end
    asserts++; if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL short_no_valid got %b exp 0", bus.m_valid); end
    for (int b = 0; b < int'(N); b++) beat(16'd20000, b == int'(N) - 1);
    asserts++; if (bus.m_data !== 32'hFFFFFFFF) begin fails++; $display("FAIL short_next_codes got %h exp ffffffff", bus.m_data); end
    repeat (3) @(negedge clk);
    asserts++; if (err_seen - e0 !== 1) begin fails++; $display("FAIL short_err_count got %0d exp 1", err_seen - e0); end
    asserts++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL short_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (chk < exp_q.size() && chk < got_q.size()) begin
      asserts++; if (got_q[chk] !== exp_q[chk]) begin fails++; $display("FAIL short_vec[%0d] got %h exp %h", chk, got_q[chk], exp_q[chk]); end
      chk++;
    end
  endtask

  task automatic test_long_frame();
    for (int b = 0; b < int'(N); b++) beat(16'($urandom), 1'b0);
    asserts++; if (bus.err_framing !== 1'b1) begin fails++; $display("FAIL long_err_pulse got %b exp 1", bus.err_framing); end
    asserts++; if (bus.m_valid !== 1'b1) begin fails++; $display("FAIL long_valid got %b exp 1", bus.m_valid); end
    for (int b = 0; b < 3; b++) beat(16'($urandom), b == 2);
    for (int b = 0; b < int'(N); b++) beat(16'($urandom), b == int'(N) - 1);
    repeat (3) @(negedge clk);
    asserts++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL long_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (chk < exp_q.size() && chk < got_q.size()) begin
      asserts++; if (got_q[chk] !== exp_q[chk]) begin fails++; $display("FAIL long_vec[%0d] got %h exp %h", chk, got_q[chk], exp_q[chk]); end
      chk++;
    end
    asserts++; if (err_seen !== exp_err) begin fails++; $display("FAIL long_err got %0d exp %0d", err_seen, exp_err); end
  endtask

  task automatic test_backpressure();
    logic [VW-1:0] snap;
    bus.m_ready = 1'b0;
    for (int b = 0; b < int'(N); b++) beat(16'($urandom), b == int'(N) - 1);
    snap = bus.m_data;
    asserts++; if (snap !== exp_q[exp_q.size()-1]) begin fails++; $display("FAIL bp_data got %h exp %h", snap, exp_q[exp_q.size()-1]); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      asserts++;
      if (bus.m_valid !== 1'b1 || bus.s_ready !== 1'b0 || bus.m_data !== snap) begin
        fails++;
        $display("FAIL bp_hold c=%0d got v=%b r=%b d=%h exp v=1 r=0 d=%h", c, bus.m_valid, bus.s_ready, bus.m_data, snap);
      end
    end
    bus.m_ready = 1'b1;
    @(negedge clk);
    asserts++; if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin fails++; $display("FAIL bp_release got v=%b r=%b exp v=0 r=1", bus.m_valid, bus.s_ready); end
    repeat (2) @(negedge clk);
    asserts++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL bp_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (chk < exp_q.size() && chk < got_q.size()) begin
      asserts++; if (got_q[chk] !== exp_q[chk]) begin fails++; $display("FAIL bp_vec[%0d] got %h exp %h", chk, got_q[chk], exp_q[chk]); end
      chk++;
    end
  endtask

  task automatic test_back_to_back();
    int c0 = cyc;
    for (int fr = 0; fr < 3; fr++)
      for (int b = 0; b < int'(N); b++) beat(16'($urandom), b == int'(N) - 1);
    asserts++; if (cyc - c0 !== 3 * (int'(N) + 1) - 1) begin fails++; $display("FAIL b2b_cycles got %0d exp %0d", cyc - c0, 3 * (int'(N) + 1) - 1); end
    repeat (3) @(negedge clk);
    asserts++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL b2b_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (chk < exp_q.size() && chk < got_q.size()) begin
      asserts++; if (got_q[chk] !== exp_q[chk]) begin fails++; $display("FAIL b2b_vec[%0d] got %h exp %h", chk, got_q[chk], exp_q[chk]); end
      chk++;
    end
  endtask

  task automatic test_random();
    for (int fr = 0; fr < 14; fr++) begin
      int kind = $urandom_range(0, 9);
      int len;
      int mid;
      if ($urandom_range(0, 1) == 1) begin
        int f = $urandom_range(0, N - 1);
        int base = $urandom_range(0, 40000) - 20000;
        for (int k = 0; k < int'(NT); k++) begin
          if (kind == 9) cfg_write(f, k, 16'($urandom));
          else           cfg_write(f, k, 16'(base + k * $urandom_range(1, 3000)));
        end
      end
      if (kind < 6)      len = N;
      else if (kind < 8) len = $urandom_range(1, N - 1);
      else               len = N + $urandom_range(1, 3);
      mid = $urandom_range(0, len - 1);
      for (int b = 0; b < len; b++) begin
        int f = draining ? 0 : part;
        int r = $urandom_range(0, 3);
        logic [FW-1:0] d;
        if (b == mid && fr % 2 == 1) cfg_write($urandom_range(0, N - 1), $urandom_range(0, NT - 1), 16'($urandom));
        if (r == 0) d = 16'($urandom);
        else        d = 16'(thr_m[f][$urandom_range(0, NT - 1)] + r - 2);
        beat(d, b == len - 1);
      end
    end
    repeat (4) @(negedge clk);
    asserts++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (chk < exp_q.size() && chk < got_q.size()) begin
      asserts++; if (got_q[chk] !== exp_q[chk]) begin fails++; $display("FAIL rand_vec[%0d] got %h exp %h", chk, got_q[chk], exp_q[chk]); end
      chk++;
    end
    asserts++; if (err_seen !== exp_err) begin fails++; $display("FAIL rand_err got %0d exp %0d", err_seen, exp_err); end
  endtask

  task automatic test_reset_midframe();
    int n0;
    for (int k = 0; k < int'(NT); k++) cfg_write(2, k, 16'(30000 + k * 1000));
    for (int b = 0; b < 7; b++) beat(16'($urandom), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    asserts++;
    if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_data !== '0 || bus.err_framing !== 1'b0) begin
      fails++;
      $display("FAIL midrst_values got r=%b v=%b d=%h e=%b exp r=0 v=0 d=0 e=0", bus.s_ready, bus.m_valid, bus.m_data, bus.err_framing);
    end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    asserts++; if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL midrst_s_ready got %b exp 1", bus.s_ready); end
    n0 = got_q.size();
    for (int b = 0; b < int'(N); b++) beat((b == 2) ? 16'd20000 : 16'($urandom), b == int'(N) - 1);
    repeat (3) @(negedge clk);
    asserts++; if (got_q.size() - n0 !== 1) begin fails++; $display("FAIL midrst_one_vector got %0d exp 1", got_q.size() - n0); end
    asserts++; if (got_q.size() !== exp_q.size()) begin fails++; $display("FAIL midrst_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (chk < exp_q.size() && chk < got_q.size()) begin
      asserts++; if (got_q[chk] !== exp_q[chk]) begin fails++; $display("FAIL midrst_vec[%0d] got %h exp %h", chk, got_q[chk], exp_q[chk]); end
      chk++;
    end
    asserts++; if (err_seen !== exp_err) begin fails++; $display("FAIL midrst_err got %0d exp %0d", err_seen, exp_err); end
  endtask

  initial begin
    test_reset();
    test_default_quant();
    test_program_thr();
    test_short_frame();
    test_long_frame();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
